// File: rtl/alien_pixel_engine.sv
// Renders a row of five aliens into a VGA frame buffer: initial draw, per-alien erase on kill,
// and a one-pixel downward shift of the whole row. One registered pixel write per cycle.
module alien_pixel_engine #(
    parameter int         WIDTH        = 12,
    parameter int         HEIGHT       = 10,
    parameter int         GAP          = 20,
    parameter int         START_X      = 10,
    parameter int         START_Y      = 10,
    parameter logic [2:0] ALIEN_COLOUR = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kill1,
    input  logic       kill2,
    input  logic       kill3,
    input  logic       kill4,
    input  logic       kill5,
    input  logic       moveDown,
    input  logic [7:0] alienTopX,
    input  logic [7:0] alienBottomX,
    input  logic [6:0] alienTopY,
    input  logic [6:0] alienBottomY,
    output logic       cleared1,
    output logic       cleared2,
    output logic       cleared3,
    output logic       cleared4,
    output logic       cleared5,
    output logic       clearedShift,
    output logic [7:0] vgaX,
    output logic [6:0] vgaY,
    output logic [2:0] vgaColour,
    output logic       vgaPlot
);

    typedef enum logic [2:0] {
        INIT_DRAW,
        IDLE,
        KILL_ERASE,
        KILL_ACK,
        SHIFT_ERASE,
        SHIFT_MOVE,
        SHIFT_DRAW,
        SHIFT_ACK
    } state_t;

    // Current pixel plus the rectangle it belongs to; x/y drive vgaX/vgaY directly.
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] idx;
        logic [7:0] x0;
        logic [7:0] x1;
        logic [6:0] y1;
    } scan_t;

    localparam logic [7:0] W_M1     = 8'(WIDTH - 1);
    localparam logic [6:0] H_M1     = 7'(HEIGHT - 1);
    localparam logic [6:0] ROW_MAX  = 7'(128 - HEIGHT);
    localparam logic [6:0] ROW_INIT = 7'(START_Y);

    function automatic scan_t alien_rect(input logic [2:0] idx, input logic [6:0] row);
        scan_t s;
        s.x0  = 8'(START_X + int'(idx) * (WIDTH + GAP));
        s.x1  = s.x0 + W_M1;
        s.x   = s.x0;
        s.y   = row;
        s.y1  = row + H_M1;
        s.idx = idx;
        return s;
    endfunction

    function automatic scan_t rect_step(input scan_t s);
        scan_t n = s;
        if (s.x != s.x1) begin
            n.x = s.x + 8'd1;
        end else begin
            n.x = s.x0;
            n.y = s.y + 7'd1;
        end
        return n;
    endfunction

    // Returns {found, index} of the lowest alive alien at or above 'from'.
    function automatic logic [3:0] find_alive(input logic [4:0] mask, input logic [3:0] from);
        logic [3:0] r = 4'b0;
        for (int i = 4; i >= 0; i--) begin
            if (mask[i] && i >= int'(from)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [6:0] row_q, row_d;
    logic [4:0] alive_q, alive_d;
    scan_t      scan_q, scan_d;
    logic       plot_q, plot_d;
    logic [2:0] colour_q, colour_d;

    logic [4:0] kill_vec;
    logic [2:0] kill_idx;
    logic [3:0] first_alive, next_alive;
    logic       rect_done, box_empty, adv_valid;
    scan_t      adv_scan;

    assign kill_vec    = {kill5, kill4, kill3, kill2, kill1};
    assign first_alive = find_alive(alive_q, 4'd0);
    assign next_alive  = find_alive(alive_q, {1'b0, scan_q.idx} + 4'd1);
    assign rect_done   = (scan_q.x == scan_q.x1) && (scan_q.y == scan_q.y1);
    assign box_empty   = (alienBottomX < alienTopX) || (alienBottomY < alienTopY);

    always_comb begin
        kill_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (kill_vec[i]) kill_idx = 3'(i);
        end
    end

    // Next pixel of a multi-alien scan: finish this rectangle, then hop to the next alive alien.
    always_comb begin
        adv_valid = 1'b1;
        adv_scan  = rect_step(scan_q);
        if (rect_done) begin
            if (next_alive[3]) begin
                adv_scan = alien_rect(next_alive[2:0], row_q);
            end else begin
                adv_scan  = scan_q;
                adv_valid = 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
        state_d  = state_q;
        row_d    = row_q;
        alive_d  = alive_q;
        scan_d   = scan_q;
        colour_d = colour_q;
        plot_d   = 1'b0;

        case (state_q)
            INIT_DRAW: begin
                if (!plot_q) begin
                    scan_d   = alien_rect(3'd0, row_q);
                    colour_d = ALIEN_COLOUR;
                    plot_d   = 1'b1;
                end else if (adv_valid) begin
                    scan_d = adv_scan;
                    plot_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (moveDown) begin
                    if (first_alive[3]) begin
                        state_d  = SHIFT_ERASE;
                        scan_d   = alien_rect(first_alive[2:0], row_q);
                        colour_d = 3'b000;
                        plot_d   = 1'b1;
                    end else begin
                        state_d = SHIFT_MOVE;
                    end
                end else if (|kill_vec) begin
                    alive_d[kill_idx] = 1'b0;
                    scan_d = '{x: alienTopX, y: alienTopY, idx: kill_idx,
                               x0: alienTopX, x1: alienBottomX, y1: alienBottomY};
                    if (box_empty) begin
                        state_d = KILL_ACK;
                    end else begin
                        state_d  = KILL_ERASE;
                        colour_d = 3'b000;
                        plot_d   = 1'b1;
                    end
                end
            end

            KILL_ERASE: begin
                if (!rect_done) begin
                    scan_d = rect_step(scan_q);
                    plot_d = 1'b1;
                end else begin
                    state_d = KILL_ACK;
                end
            end

            KILL_ACK: begin
                if (!kill_vec[scan_q.idx]) state_d = IDLE;
            end

            SHIFT_ERASE: begin
                if (adv_valid) begin
                    scan_d = adv_scan;
                    plot_d = 1'b1;
                end else begin
                    state_d = SHIFT_MOVE;
                end
            end

            SHIFT_MOVE: begin
                row_d = (row_q == ROW_MAX) ? row_q : row_q + 7'd1;
                if (first_alive[3]) begin
                    state_d  = SHIFT_DRAW;
                    scan_d   = alien_rect(first_alive[2:0], row_d);
                    colour_d = ALIEN_COLOUR;
                    plot_d   = 1'b1;
                end else begin
                    state_d = SHIFT_ACK;
                end
            end

            SHIFT_DRAW: begin
                if (adv_valid) begin
                    scan_d = adv_scan;
                    plot_d = 1'b1;
                end else begin
                    state_d = SHIFT_ACK;
                end
            end

            SHIFT_ACK: begin
                if (!moveDown) state_d = IDLE;
            end

            default: state_d = INIT_DRAW;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates so every flop samples the same pre-edge values.
        if (reset) begin
            state_q  <= INIT_DRAW;
            row_q    <= ROW_INIT;
            alive_q  <= 5'b11111;
            scan_q   <= '0;
            plot_q   <= 1'b0;
            colour_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            alive_q  <= alive_d;
            scan_q   <= scan_d;
            plot_q   <= plot_d;
            colour_q <= colour_d;
        end
    end

    assign vgaX      = scan_q.x;
    assign vgaY      = scan_q.y;
    assign vgaColour = colour_q;
    assign vgaPlot   = plot_q;

    assign cleared1     = (state_q == KILL_ACK) && (scan_q.idx == 3'd0);
    assign cleared2     = (state_q == KILL_ACK) && (scan_q.idx == 3'd1);
    assign cleared3     = (state_q == KILL_ACK) && (scan_q.idx == 3'd2);
    assign cleared4     = (state_q == KILL_ACK) && (scan_q.idx == 3'd3);
    assign cleared5     = (state_q == KILL_ACK) && (scan_q.idx == 3'd4);
    assign clearedShift = (state_q == SHIFT_ACK);

endmodule

// File: tb/tb_alien_pixel_engine.sv
// Directed bench for alien_pixel_engine: captures plotted pixels into a frame buffer and
// compares against an image painted from the alien geometry, plus timing of scans and acks.
module tb_alien_pixel_engine;

    localparam logic [2:0] ALIEN = 3'b010;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] kill_v;
    logic       moveDown;
    logic [7:0] topX, botX;
    logic [6:0] topY, botY;
    logic       cleared1, cleared2, cleared3, cleared4, cleared5, clearedShift;
    logic [7:0] vgaX;
    logic [6:0] vgaY;
    logic [2:0] vgaColour;
    logic       vgaPlot;

    wire [5:0] cleared_vec = {clearedShift, cleared5, cleared4, cleared3, cleared2, cleared1};

    alien_pixel_engine dut (
        .clk(clk), .reset(reset),
        .kill1(kill_v[0]), .kill2(kill_v[1]), .kill3(kill_v[2]), .kill4(kill_v[3]), .kill5(kill_v[4]),
        .moveDown(moveDown),
        .alienTopX(topX), .alienBottomX(botX), .alienTopY(topY), .alienBottomY(botY),
        .cleared1(cleared1), .cleared2(cleared2), .cleared3(cleared3), .cleared4(cleared4),
        .cleared5(cleared5), .clearedShift(clearedShift),
        .vgaX(vgaX), .vgaY(vgaY), .vgaColour(vgaColour), .vgaPlot(vgaPlot)
    );

    always #5 clk = ~clk;

    logic [2:0] fb     [0:255][0:127];
    logic [2:0] exp_fb [0:255][0:127];

    int n_checks = 0;
    int n_fail   = 0;
    int multi_ack = 0;

    int n_plot, n_black, n_colr, first_cyc, last_cyc, ack_cyc, first_colr_y;
    logic [7:0] first_x, last_x;
    logic [6:0] first_y, last_y;
    logic [5:0] ack_vec;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic paint(input int x0, input int x1, input int y0, input int y1, input logic [2:0] col);
        for (int x = x0; x <= x1; x++)
            for (int y = y0; y <= y1; y++)
                exp_fb[x][y] = col;
    endtask

    task automatic paint_aliens(input logic [4:0] mask, input int row, input logic [2:0] col);
        for (int i = 0; i < 5; i++)
            if (mask[i]) paint(10 + 32 * i, 21 + 32 * i, row, row + 9, col);
    endtask

    function automatic int fb_mismatches();
        int m = 0;
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++)
                if (fb[x][y] !== exp_fb[x][y]) m++;
        return m;
    endfunction

    task automatic drive_box(input int tx, input int bx, input int ty, input int by);
        topX = 8'(tx);
        botX = 8'(bx);
        topY = 7'(ty);
        botY = 7'(by);
    endtask

    // Watches up to max_cyc cycles (sampled at negedge), stopping at the first acknowledge.
    task automatic scan(input int max_cyc);
        n_plot = 0; n_black = 0; n_colr = 0;
        first_cyc = 0; last_cyc = 0; ack_cyc = 0; first_colr_y = -1; ack_vec = '0;
        first_x = '0; first_y = '0; last_x = '0; last_y = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (!$onehot0(cleared_vec)) multi_ack++;
            if (vgaPlot) begin
                if (first_cyc == 0) begin
                    first_cyc = c;
                    first_x   = vgaX;
                    first_y   = vgaY;
                end
                if (vgaColour == 3'b000) n_black++;
                if (vgaColour == ALIEN) begin
                    n_colr++;
                    if (first_colr_y < 0) first_colr_y = int'(vgaY);
                end
                n_plot++;
                last_cyc = c;
                last_x   = vgaX;
                last_y   = vgaY;
                fb[vgaX][vgaY] = vgaColour;
            end
            if (cleared_vec != 6'b0) begin
                ack_cyc = c;
                ack_vec = cleared_vec;
                break;
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, e108, d108;
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++) begin
                fb[x][y]     = 3'b111;
                exp_fb[x][y] = 3'b111;
            end
        reset = 1'b1; kill_v = '0; moveDown = 1'b0;
        drive_box(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_plot", vgaPlot, 0);
        check("reset_x", vgaX, 0);
        check("reset_y", vgaY, 0);
        check("reset_colour", vgaColour, 0);
        check("reset_cleared", cleared_vec, 0);

        // Initial draw
        reset = 1'b0;
        scan(605);
        check("init_plots", n_plot, 600);
        check("init_colour", n_colr, 600);
        check("init_first_cyc", first_cyc, 1);
        check("init_last_cyc", last_cyc, 600);
        check("init_first_xy", {first_x, first_y}, {8'd10, 7'd10});
        check("init_last_xy", {last_x, last_y}, {8'd149, 7'd19});
        paint_aliens(5'b11111, 10, ALIEN);
        check("init_image", fb_mismatches(), 0);

        // kill2 with box (42,20)-(53,29)
        drive_box(42, 53, 20, 29);
        kill_v = 5'b00010;
        scan(200);
        check("kill2_plots", n_black, 120);
        check("kill2_first_cyc", first_cyc, 1);
        check("kill2_ack_cyc", ack_cyc, 121);
        check("kill2_ack_vec", ack_vec, 6'b000010);
        check("kill2_first_xy", {first_x, first_y}, {8'd42, 7'd20});
        check("kill2_last_xy", {last_x, last_y}, {8'd53, 7'd29});
        paint(42, 53, 20, 29, 3'b000);
        repeat (3) @(negedge clk);
        check("kill2_ack_hold", cleared_vec, 6'b000010);
        kill_v = '0;
        @(negedge clk);
        check("kill2_ack_drop", cleared_vec, 0);

        // Shift with alien index 1 dead
        moveDown = 1'b1;
        scan(1100);
        check("shift1_black", n_black, 480);
        check("shift1_colour", n_colr, 480);
        check("shift1_first_cyc", first_cyc, 1);
        check("shift1_holes", last_cyc - first_cyc + 1 - n_plot, 1);
        check("shift1_ack_cyc", ack_cyc, 962);
        check("shift1_ack_vec", ack_vec, 6'b100000);
        check("shift1_first_xy", {first_x, first_y}, {8'd10, 7'd10});
        check("shift1_last_xy", {last_x, last_y}, {8'd149, 7'd20});
        paint_aliens(5'b11101, 10, 3'b000);
        paint_aliens(5'b11101, 11, ALIEN);
        check("shift1_image", fb_mismatches(), 0);
        moveDown = 1'b0;
        @(negedge clk);
        check("shift1_ack_drop", cleared_vec, 0);

        // moveDown and kill1 together; kill1 uses an empty box (bottomX < topX)
        moveDown = 1'b1;
        kill_v   = 5'b00001;
        drive_box(60, 50, 0, 0);
        scan(1100);
        check("prio_shift_first", ack_vec, 6'b100000);
        check("prio_shift_plots", n_plot, 960);
        check("prio_shift_ack_cyc", ack_cyc, 962);
        paint_aliens(5'b11101, 11, 3'b000);
        paint_aliens(5'b11101, 12, ALIEN);
        moveDown = 1'b0;
        scan(10);
        check("prio_kill1_ack_vec", ack_vec, 6'b000001);
        check("prio_kill1_ack_cyc", ack_cyc, 2);
        check("prio_kill1_plots", n_plot, 0);
        kill_v = '0;
        @(negedge clk);
        check("prio_image", fb_mismatches(), 0);

        // Kill an already-dead alien: 2x2 box still erased
        drive_box(0, 1, 0, 1);
        kill_v = 5'b00010;
        scan(20);
        check("dead_kill_black", n_black, 4);
        check("dead_kill_ack_cyc", ack_cyc, 5);
        check("dead_kill_last_xy", {last_x, last_y}, {8'd1, 7'd1});
        paint(0, 1, 0, 1, 3'b000);
        kill_v = '0;
        @(negedge clk);

        // Empty box with bottomY < topY on kill5
        drive_box(0, 5, 9, 3);
        kill_v = 5'b10000;
        scan(10);
        check("emptyy_ack_cyc", ack_cyc, 1);
        check("emptyy_ack_vec", ack_vec, 6'b010000);
        check("emptyy_plots", n_plot, 0);
        kill_v = '0;
        @(negedge clk);

        // kill3 beats kill4; kill4 is served once kill3 drops
        drive_box(200, 200, 100, 100);
        kill_v = 5'b01100;
        scan(10);
        check("k34_ack_vec", ack_vec, 6'b000100);
        check("k34_ack_cyc", ack_cyc, 2);
        check("k34_plots", n_plot, 1);
        kill_v = 5'b01000;
        scan(10);
        check("k4_ack_vec", ack_vec, 6'b001000);
        check("k4_ack_cyc", ack_cyc, 3);
        check("k4_last_xy", {last_x, last_y}, {8'd200, 7'd100});
        paint(200, 200, 100, 100, 3'b000);
        kill_v = '0;
        @(negedge clk);
        check("kills_image", fb_mismatches(), 0);

        // All aliens dead: shift plots nothing but still acknowledges
        moveDown = 1'b1;
        scan(10);
        check("dead_shift_ack_cyc", ack_cyc, 2);
        check("dead_shift_ack_vec", ack_vec, 6'b100000);
        check("dead_shift_plots", n_plot, 0);

        // Reset while acknowledging drops the ack on the next edge and restores row/alive
        reset = 1'b1;
        @(negedge clk);
        check("rst_ack_drop", cleared_vec, 0);
        check("rst_plot", vgaPlot, 0);
        moveDown = 1'b0;
        reset    = 1'b0;
        scan(605);
        check("reinit_plots", n_colr, 600);
        check("reinit_first_xy", {first_x, first_y}, {8'd10, 7'd10});
        check("reinit_last_xy", {last_x, last_y}, {8'd149, 7'd19});

        // Reset in the middle of SHIFT_DRAW
        moveDown = 1'b1;
        scan(610);
        check("mid_draw_black", n_black, 600);
        check("mid_draw_colour", n_colr, 9);
        reset    = 1'b1;
        moveDown = 1'b0;
        @(negedge clk);
        check("mid_rst_plot", vgaPlot, 0);
        check("mid_rst_x", vgaX, 0);
        reset = 1'b0;
        scan(605);
        check("redraw_plots", n_colr, 600);
        check("redraw_first_cyc", first_cyc, 1);
        check("redraw_first_xy", {first_x, first_y}, {8'd10, 7'd10});
        check("redraw_last_xy", {last_x, last_y}, {8'd149, 7'd19});

        // Leave only alien 0 alive, then shift until the row saturates at 128-HEIGHT
        bad = 0;
        for (int k = 1; k < 5; k++) begin
            drive_box(5, 0, 0, 0);
            kill_v = 5'(1 << k);
            scan(5);
            if (ack_cyc != 1 || n_plot != 0) bad++;
            kill_v = '0;
            @(negedge clk);
        end
        check("empty_kills", bad, 0);

        bad = 0; e108 = 0; d108 = 0;
        for (int k = 1; k <= 109; k++) begin
            moveDown = 1'b1;
            scan(300);
            if (ack_cyc != 242 || n_black != 120 || n_colr != 120) bad++;
            if (k == 108) begin
                e108 = int'(first_y);
                d108 = first_colr_y;
            end
            moveDown = 1'b0;
            @(negedge clk);
        end
        check("sat_shift_shape", bad, 0);
        check("sat_k108_erase_y", e108, 117);
        check("sat_k108_draw_y", d108, 118);
        check("sat_k109_erase_y", first_y, 118);
        check("sat_k109_draw_y", first_colr_y, 118);
        check("sat_k109_last_y", last_y, 127);
        check("onehot_acks", multi_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alien_pixel_engine.md
ALIEN_PIXEL_ENGINE -- requirements
Module: alien_pixel_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 12, alien width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 10, alien height in pixels.
REQ-003 SHALL have parameter GAP, default 20, horizontal gap between aliens in pixels.
REQ-004 SHALL have parameter START_X, default 10, left X of alien 0.
REQ-005 SHALL have parameter START_Y, default 10, initial top Y of the alien row.
REQ-006 SHALL have parameter ALIEN_COLOUR, default 3'b010, draw colour; background colour is fixed at 3'b000.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous, active-high.
REQ-009 SHALL have ports kill1..kill5, input, 1 each, level request to erase alien N.
REQ-010 SHALL have port moveDown, input, 1, level request to shift the alien row down one pixel.
REQ-011 SHALL have ports alienTopX/alienBottomX, input, 8 each, inclusive X bounds of the kill box.
REQ-012 SHALL have ports alienTopY/alienBottomY, input, 7 each, inclusive Y bounds of the kill box.
REQ-013 SHALL have ports cleared1..cleared5 and clearedShift, output, 1 each, level acknowledges.
REQ-014 SHALL have ports vgaX (output, 8), vgaY (output, 7), vgaColour (output, 3) and vgaPlot (output, 1), forming a pixel write strobe.

Function
REQ-015 SHALL occupy alien i (0..4) at X [START_X+i*(WIDTH+GAP), +WIDTH-1] and Y [rowY, rowY+HEIGHT-1], where rowY is an internal 7-bit register.
REQ-016 SHALL hold an internal 5-bit alive mask.
REQ-017 SHALL implement the states INIT_DRAW, IDLE, KILL_ERASE, KILL_ACK, SHIFT_ERASE, SHIFT_MOVE, SHIFT_DRAW and SHIFT_ACK.
REQ-018 SHALL write exactly one pixel per cycle while plotting, with vgaPlot=1 only in cycles that carry a valid pixel; all pixel outputs are registered.
REQ-019 SHALL scan rectangles X-inner, Y-outer, starting at the top-left and ending at the bottom-right.
REQ-020 INIT_DRAW SHALL draw every alien in ALIEN_COLOUR at START_Y, then go to IDLE, with requests ignored until then.
REQ-021 IDLE SHALL sample requests each cycle with priority moveDown > kill1 > kill2 > kill3 > kill4 > kill5.
REQ-022 On a kill SHALL latch the box and index, clear alive[N] and enter KILL_ERASE; the first pixel appears the next cycle.
REQ-023 KILL_ERASE SHALL paint the latched box with colour 0.
REQ-024 If alienBottomX<alienTopX or alienBottomY<alienTopY, SHALL plot zero pixels and go directly to KILL_ACK.
REQ-025 KILL_ACK SHALL hold clearedN=1, rising the cycle after the last pixel, until killN is sampled low, then return to IDLE.
REQ-026 A kill of an already-dead alien SHALL still erase and acknowledge.
REQ-027 SHIFT_ERASE SHALL paint each alive alien at rowY with colour 0; dead aliens produce no pixels.
REQ-028 SHIFT_MOVE SHALL be 1 cycle with no plot, and SHALL set rowY=rowY+1 unless rowY==128-HEIGHT, where rowY saturates.
REQ-029 SHIFT_DRAW SHALL paint each alive alien at the new rowY in ALIEN_COLOUR.
REQ-030 SHIFT_ACK SHALL hold clearedShift=1 until moveDown is sampled low, then return to IDLE.
REQ-031 With alive==0, a shift SHALL plot nothing and still update rowY and acknowledge.
REQ-032 SHALL assert at most one cleared output at any time.
REQ-033 A request change during erase/draw SHALL have no effect until the ACK state.
REQ-034 All X/Y arithmetic SHALL be unsigned and truncated to port widths, with no wrap checks beyond REQ-028.

Reset
REQ-035 reset=1 at a clock edge SHALL force INIT_DRAW, rowY=START_Y, alive=5'b11111, vgaPlot=0, vgaX=0, vgaY=0, vgaColour=0 and all cleared outputs=0.
REQ-036 Reset mid-operation SHALL abandon the current scan and drop any acknowledge on the next edge.

Verification
REQ-037 Release reset -> exactly 5*120=600 vgaPlot cycles at colour 3'b010 covering X 10..21, 42..53, 74..85, 106..117, 138..149 and Y 10..19, then IDLE.
REQ-038 kill2 high with box (42,20)-(53,29) -> 120 black pixels starting the next cycle, cleared2 rises the following cycle, and falls one cycle after kill2 falls.
REQ-039 After killing alien 2, moveDown -> 480 black pixels at Y 10..19, 1 idle cycle, 480 coloured pixels at Y 11..20 excluding X 42..53, then clearedShift=1.
REQ-040 moveDown and kill1 high together in IDLE -> shift served first, and kill1 is served after moveDown drops.
REQ-041 Box with alienBottomX<alienTopX -> no pixels, and clearedN rises one cycle after the request is sampled.
REQ-042 Assert reset during SHIFT_DRAW -> rowY=10, alive=11111, and the initial 600-pixel draw restarts.
